wormhole_sw_arbiter_4port: RTL

- Packet-aware switch allocator for the 4-port mesh router (ports X1, X2, Y, LOCAL).
- Shares each output port among the four input pipelines with a per-output round-robin arbiter.
- Locks an output to its winning input from head flit to tail flit, so multi-flit packets never interleave.
- Honours the downstream full flags and drives the crossbar select codes and the input pipeline advance enables.

---
 rtl/wormhole_sw_arbiter_4port.sv | 133 +++++++++++++
 1 files changed

// File: rtl/wormhole_sw_arbiter_4port.sv
// Packet-aware switch allocator for the 4-port mesh router.
// Each output has its own round-robin arbiter and can be locked to one input from head flit to tail flit.
module wormhole_sw_arbiter_4port #(
  parameter int LOCK_EN  = 1,
  parameter int PTR_INIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  in_valid,
  input  logic [11:0] in_dst,
  input  logic [3:0]  in_last,
  input  logic [3:0]  out_full,
  output logic [3:0]  in_grant,
  output logic [11:0] out_sel,
  output logic [3:0]  out_valid,
  output logic [3:0]  out_locked,
  output logic        err_sticky
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam logic [2:0] SEL_STOP  = 3'd7;

  logic [2:0]  dst [4];
  logic [15:0] lock_flat;
  logic [15:0] gnt_flat;
  logic [3:0]  own_err;
  logic [3:0]  locked_in;
  logic [3:0]  gnt_or;
  logic        err_now;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      dst[i] = in_dst[3*i +: 3];
    end
  end

  // Inputs currently owned by a locked output are excluded from every idle arbiter,
  // which is also what masks an owner that strays to a different destination.
  always_comb begin
    locked_in = '0;
    gnt_or    = '0;
    err_now   = |own_err;
    for (int unsigned o = 0; o < 4; o++) begin
      locked_in = locked_in | lock_flat[4*o +: 4];
      gnt_or    = gnt_or | gnt_flat[4*o +: 4];
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (in_valid[i] && dst[i][2]) err_now = 1'b1;
    end
  end

  assign in_grant = rst_n ? gnt_or : '0;

  for (genvar o = 0; o < 4; o++) begin : g_out
    logic [0:0] state_q;
    logic [1:0] owner_q;
    logic [1:0] ptr_q;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic [3:0] req;
    logic [3:0] cand;
    logic [3:0] gnt;
    logic [2:0] sel_q;
    logic       valid_q;

    always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
        req[i] = in_valid[i] && (dst[i] == 3'(o));
      end
    end

    always_comb begin
      cand  = req & ~locked_in;
      gnt   = '0;
      win   = '0;
      idx   = '0;
      found = 1'b0;
      if (state_q == ST_LOCKED) begin
        win = owner_q;
        if (req[owner_q] && !out_full[o]) gnt[owner_q] = 1'b1;
      end else begin
        for (int unsigned off = 0; off < 4; off++) begin
          idx = ptr_q + 2'(off);
          if (!found && cand[idx]) begin
            found = 1'b1;
            win   = idx;
          end
        end
        if (found && !out_full[o]) gnt[win] = 1'b1;
      end
    end

    assign gnt_flat[4*o +: 4]  = gnt;
    assign lock_flat[4*o +: 4] = (state_q == ST_LOCKED) ? (4'b0001 << owner_q) : 4'b0000;
    assign own_err[o] = (state_q == ST_LOCKED) && in_valid[owner_q] && (dst[owner_q] != 3'(o));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        owner_q <= '0;
        ptr_q   <= 2'(PTR_INIT);
        sel_q   <= SEL_STOP;
        valid_q <= 1'b0;
      end else begin
        valid_q <= |gnt;
        sel_q   <= (|gnt) ? {1'b0, win} : SEL_STOP;
        if (state_q == ST_IDLE) begin
          if (|gnt) begin
            ptr_q <= win + 2'd1;
            if ((LOCK_EN != 0) && !in_last[win]) begin
              state_q <= ST_LOCKED;
              owner_q <= win;
            end
          end
        end else if ((|gnt) && in_last[owner_q]) begin
          state_q <= ST_IDLE;
        end
      end
    end

    assign out_sel[3*o +: 3] = sel_q;
    assign out_valid[o]      = valid_q;
    assign out_locked[o]     = (state_q == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_sticky <= 1'b0;
    else if (err_now) err_sticky <= 1'b1;
  end

endmodule
